// File: rtl/hilo_unit.sv
// HI/LO register owner: captures multiply/divide results, holds them through a
// modelled latency, services MTHI/MTLO/MFHI/MFLO and stalls the pipe meanwhile.
module hilo_unit #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  ALU_OP,
   input  logic [31:0] Y,
   input  logic [31:0] Result,
   input  logic [31:0] Result2,
   input  logic [2:0]  HiLo_OP,
   input  logic [31:0] WData,
   input  logic        cancel,
   output logic [31:0] RData,
   output logic        Stall,
   output logic        Busy,
   output logic        DivZero
);

   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [2:0] HL_MTHI = 3'd1;
   localparam logic [2:0] HL_MTLO = 3'd2;
   localparam logic [2:0] HL_MFHI = 3'd3;
   localparam logic [2:0] HL_MFLO = 3'd4;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [31:0]      phi;
   logic [31:0]      plo;
   logic [CNT_W-1:0] cnt;
   logic             div_zero;

   logic is_md;
   logic hl_use;
   logic issue;
   logic accept;
   logic div0;

   assign is_md  = (ALU_OP == OP_MUL) || (ALU_OP == OP_DIV);
   assign hl_use = (HiLo_OP >= HL_MTHI) && (HiLo_OP <= HL_MFLO);

   assign Busy    = (state == BUSY);
   assign Stall   = Busy & en & (hl_use | is_md);
   assign issue   = en & ~Stall;
   assign accept  = (state == IDLE) & en & is_md & ~cancel;
   assign div0    = accept & (ALU_OP == OP_DIV) & (Y == 32'd0);
   assign DivZero = div_zero;

   // MFHI/MFLO read the current architectural value; zero when not issuing
   always_comb begin
      RData = 32'd0;
      if (issue) begin
         if (HiLo_OP == HL_MFHI)      RData = hi;
         else if (HiLo_OP == HL_MFLO) RData = lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hi       <= 32'd0;
         lo       <= 32'd0;
         phi      <= 32'd0;
         plo      <= 32'd0;
         cnt      <= '0;
         div_zero <= 1'b0;
      end else begin
         div_zero <= div0;

         // MT writes can only issue while no result is pending, so they never
         // collide with a commit
         if (issue && HiLo_OP == HL_MTHI) hi <= WData;
         if (issue && HiLo_OP == HL_MTLO) lo <= WData;

         case (state)
            IDLE: begin
               if (accept && !div0) begin
                  phi   <= Result2;
                  plo   <= Result;
                  cnt   <= (ALU_OP == OP_MUL) ? MUL_CNT : DIV_CNT;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // cancel beats commit in the same cycle
               if (cancel) begin
                  phi   <= 32'd0;
                  plo   <= 32'd0;
                  state <= IDLE;
               end else if (cnt == '0) begin
                  hi    <= phi;
                  lo    <= plo;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
